// File: rtl/freq_prog_pkg.sv
// Shared constants and types for the programmable multi-channel clock divider.
package freq_prog_pkg;

    localparam int          CNT_W_DEF       = 32;
    localparam int unsigned DIV_DEFAULT_DEF = 32'd1500000000;
    localparam int          CH_IDX_W        = 4;

    typedef logic [CNT_W_DEF-1:0] div_t;

endpackage

// File: rtl/freq_prog_ch.sv
// One divider channel: counter, shadow/active divisor, square-wave output and toggle tick.
// Tick generation is compiled in only when FREQ_PROG_TICK_EN is defined; otherwise o_tick is 0.
module freq_prog_ch
    import freq_prog_pkg::*;
#(
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int unsigned DIV_DEFAULT = DIV_DEFAULT_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_div_val,
    output logic             o_relojs,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_act;
    logic [CNT_W-1:0] r_shd;
    logic             r_relojs;
    logic             w_term;

    assign w_term = (r_cnt == r_act);

    // act only changes at a terminal count or while stopped, so a half-period is never cut short
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt    <= '0;
            r_act    <= CNT_W'(DIV_DEFAULT);
            r_shd    <= CNT_W'(DIV_DEFAULT);
            r_relojs <= 1'b0;
        end else begin
            if (i_wr) begin
                r_shd <= i_div_val;
            end
            if (!i_en) begin
                r_cnt    <= '0;
                r_relojs <= 1'b0;
                r_act    <= r_shd;
            end else if (w_term) begin
                r_cnt    <= '0;
                r_relojs <= ~r_relojs;
                r_act    <= i_wr ? i_div_val : r_shd;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_relojs = r_relojs;

`ifdef FREQ_PROG_TICK_EN
    logic r_tick;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= i_en && w_term;
        end
    end

    assign o_tick = r_tick;
`else
    assign o_tick = 1'b0;
`endif

endmodule

// File: rtl/freq_prog.sv
// Programmable N-channel clock divider: divisor write decode plus channel array.
// Define FREQ_PROG_TICK_EN to enable the per-channel toggle tick outputs.
module freq_prog
    import freq_prog_pkg::*;
#(
    parameter int          N_CH        = 4,
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int unsigned DIV_DEFAULT = DIV_DEFAULT_DEF
) (
    input  logic                reloje,
    input  logic                reset,
    input  logic [N_CH-1:0]     en,
    input  logic                div_wr,
    input  logic [CH_IDX_W-1:0] div_ch,
    input  logic [CNT_W-1:0]    div_val,
    output logic [N_CH-1:0]     relojs,
    output logic [N_CH-1:0]     tick
);

    logic [N_CH-1:0] w_wr;

    // Indices at or above N_CH match no channel and are dropped
    always_comb begin
        w_wr = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_wr[i] = div_wr && (div_ch == CH_IDX_W'(i));
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        freq_prog_ch #(
            .CNT_W       (CNT_W),
            .DIV_DEFAULT (DIV_DEFAULT)
        ) u_ch (
            .i_clk     (reloje),
            .i_reset   (reset),
            .i_en      (en[g]),
            .i_wr      (w_wr[g]),
            .i_div_val (div_val),
            .o_relojs  (relojs[g]),
            .o_tick    (tick[g])
        );
    end

endmodule
